// File: rtl/external_spike_router.sv
// Merges external stimulus spikes and routed neuron feedback spikes onto per-row synapse buses.
// Latency: ext_valid -> out_valid 1 cycle; nn_spike -> pending 1 cycle -> out_valid 2 cycles minimum.
// No backpressure: external spikes win, neuron spikes wait in a per-row/column pending bit or are dropped.
module external_spike_router #(
    parameter int NUM_SYNAPSE_ROWS = 2,
    parameter int NUM_COLS         = 2,
    parameter int ADDR_WIDTH       = 6,
    localparam int CW              = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_SYNAPSE_ROWS-1:0]            ext_valid,
    input  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] ext_addr,
    input  logic [NUM_COLS-1:0]                    nn_spike,
    input  logic                                   cfg_we,
    input  logic [CW-1:0]                          cfg_col,
    input  logic                                   cfg_enable,
    input  logic [NUM_SYNAPSE_ROWS-1:0]            cfg_row_mask,
    input  logic [ADDR_WIDTH-1:0]                  cfg_addr,
    output logic [NUM_SYNAPSE_ROWS-1:0]            out_valid,
    output logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] out_addr,
    output logic [NUM_SYNAPSE_ROWS-1:0]            drop_flag
);

    localparam int R  = NUM_SYNAPSE_ROWS;
    localparam int C  = NUM_COLS;
    localparam int AW = ADDR_WIDTH;

    logic [C-1:0]          tbl_en;
    logic [C-1:0][R-1:0]   tbl_mask;
    logic [C-1:0][AW-1:0]  tbl_addr;

    logic [R-1:0][C-1:0]   pending;
    logic [R-1:0][C-1:0]   pend_set;
    logic [R-1:0][C-1:0]   grant;
    logic [R-1:0][C-1:0]   pend_nxt;
    logic [R-1:0]          any_grant;
    logic [R-1:0]          drop_set;
    logic [R-1:0][AW-1:0]  grant_addr;
    logic [R-1:0]          out_valid_nxt;
    logic [R*AW-1:0]       out_addr_nxt;
    logic                  cfg_hit;

    // Out-of-range column indices (non power-of-two C) must not touch the table.
    assign cfg_hit = cfg_we && (32'(cfg_col) < 32'(C));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_en   <= '0;
            tbl_mask <= '0;
            tbl_addr <= '0;
        end else if (cfg_hit) begin
            tbl_en[cfg_col]   <= cfg_enable;
            tbl_mask[cfg_col] <= cfg_row_mask;
            tbl_addr[cfg_col] <= cfg_addr;
        end
    end

    always_comb begin
        pend_set      = '0;
        grant         = '0;
        any_grant     = '0;
        drop_set      = '0;
        grant_addr    = '0;
        pend_nxt      = pending;
        out_valid_nxt = '0;
        out_addr_nxt  = out_addr;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                pend_set[r][c] = nn_spike[c] & tbl_en[c] & tbl_mask[c][r];
            end
            // Lowest pending column wins; an external spike blocks all grants on the row.
            for (int c = 0; c < C; c++) begin
                if (!ext_valid[r] && !any_grant[r] && pending[r][c]) begin
                    grant[r][c]   = 1'b1;
                    any_grant[r]  = 1'b1;
                    grant_addr[r] = tbl_addr[c];
                end
            end
            for (int c = 0; c < C; c++) begin
                pend_nxt[r][c] = (pending[r][c] & ~grant[r][c]) | pend_set[r][c];
                drop_set[r]    = drop_set[r] | (pend_set[r][c] & pending[r][c] & ~grant[r][c]);
            end
            if (ext_valid[r]) begin
                out_valid_nxt[r]          = 1'b1;
                out_addr_nxt[r*AW +: AW]  = ext_addr[r*AW +: AW];
            end else if (any_grant[r]) begin
                out_valid_nxt[r]          = 1'b1;
                out_addr_nxt[r*AW +: AW]  = grant_addr[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            out_valid <= '0;
            out_addr  <= '0;
            drop_flag <= '0;
        end else begin
            pending   <= pend_nxt;
            out_valid <= out_valid_nxt;
            out_addr  <= out_addr_nxt;
            drop_flag <= drop_flag | drop_set;
        end
    end

endmodule

// File: tb/tb_external_spike_router.sv
// Directed bench for external_spike_router with R=2, C=2, ADDR_WIDTH=6.
module tb_external_spike_router;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ext_valid;
    logic [11:0] ext_addr;
    logic [1:0]  nn_spike;
    logic        cfg_we;
    logic [0:0]  cfg_col;
    logic        cfg_enable;
    logic [1:0]  cfg_row_mask;
    logic [5:0]  cfg_addr;
    logic [1:0]  out_valid;
    logic [11:0] out_addr;
    logic [1:0]  drop_flag;

    int n_tests = 0;
    int n_fail  = 0;

    external_spike_router #(
        .NUM_SYNAPSE_ROWS(2),
        .NUM_COLS(2),
        .ADDR_WIDTH(6)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ext_valid(ext_valid),
        .ext_addr(ext_addr),
        .nn_spike(nn_spike),
        .cfg_we(cfg_we),
        .cfg_col(cfg_col),
        .cfg_enable(cfg_enable),
        .cfg_row_mask(cfg_row_mask),
        .cfg_addr(cfg_addr),
        .out_valid(out_valid),
        .out_addr(out_addr),
        .drop_flag(drop_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic col, input logic en, input logic [1:0] mask,
                             input logic [5:0] addr);
        cfg_we       = 1'b1;
        cfg_col      = col;
        cfg_enable   = en;
        cfg_row_mask = mask;
        cfg_addr     = addr;
    endtask

    task automatic cfg_idle();
        cfg_we       = 1'b0;
        cfg_col      = '0;
        cfg_enable   = 1'b0;
        cfg_row_mask = '0;
        cfg_addr     = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        ext_valid = '0;
        ext_addr  = '0;
        nn_spike  = '0;
        cfg_idle();
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_addr",  32'(out_addr),  32'h0);
        check("reset_drop_flag", 32'(drop_flag), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Unwritten table: feedback spikes go nowhere.
        nn_spike = 2'b11;
        tick();
        nn_spike = 2'b00;
        for (int i = 0; i < 10; i++) begin
            check("idle_no_feedback", 32'(out_valid), 32'h0);
            tick();
        end

        // External spike on row 1 only.
        ext_valid = 2'b10;
        ext_addr  = {6'd5, 6'd0};
        tick();
        ext_valid = 2'b00;
        check("ext_row1_valid", 32'(out_valid), 32'h2);
        check("ext_row1_addr",  32'(out_addr[11:6]), 32'd5);
        tick();
        check("ext_pulse_one_cycle", 32'(out_valid), 32'h0);

        // Feedback from col0 to row0 at addr 3.
        cfg_write(1'b0, 1'b1, 2'b01, 6'd3);
        tick();
        cfg_idle();
        nn_spike = 2'b01;
        tick();
        nn_spike = 2'b00;
        check("fb_not_yet", 32'(out_valid), 32'h0);
        tick();
        check("fb_valid", 32'(out_valid), 32'h1);
        check("fb_addr",  32'(out_addr[5:0]), 32'd3);
        tick();
        check("fb_one_cycle", 32'(out_valid), 32'h0);

        // Table write coinciding with a col1 spike uses the old (disabled) entry.
        cfg_write(1'b1, 1'b1, 2'b01, 6'd7);
        nn_spike = 2'b10;
        tick();
        cfg_idle();
        nn_spike = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check("old_entry_used", 32'(out_valid), 32'h0);
            tick();
        end

        // Priority: ext first, then col0, then col1 on consecutive cycles.
        nn_spike = 2'b11;
        tick();
        nn_spike  = 2'b00;
        check("prio_pending_only", 32'(out_valid), 32'h0);
        ext_valid = 2'b01;
        ext_addr  = {6'd0, 6'd1};
        tick();
        ext_valid = 2'b00;
        check("prio_ext_valid", 32'(out_valid), 32'h1);
        check("prio_ext_addr",  32'(out_addr[5:0]), 32'd1);
        tick();
        check("prio_col0_valid", 32'(out_valid), 32'h1);
        check("prio_col0_addr",  32'(out_addr[5:0]), 32'd3);
        tick();
        check("prio_col1_valid", 32'(out_valid), 32'h1);
        check("prio_col1_addr",  32'(out_addr[5:0]), 32'd7);
        tick();
        check("prio_drained", 32'(out_valid), 32'h0);
        check("prio_no_drop", 32'(drop_flag), 32'h0);

        // Overflow: ext holds row0 while col0 spikes twice.
        ext_valid = 2'b01;
        ext_addr  = {6'd0, 6'd9};
        nn_spike  = 2'b01;
        tick();
        nn_spike = 2'b00;
        tick();
        check("ovf_no_drop_yet", 32'(drop_flag), 32'h0);
        check("ovf_ext_addr", 32'(out_addr[5:0]), 32'd9);
        nn_spike = 2'b01;
        tick();
        nn_spike = 2'b00;
        check("ovf_drop_set", 32'(drop_flag), 32'h1);
        tick();
        ext_valid = 2'b00;
        tick();
        check("ovf_release_valid", 32'(out_valid), 32'h1);
        check("ovf_release_addr",  32'(out_addr[5:0]), 32'd3);
        tick();
        check("ovf_single_spike", 32'(out_valid), 32'h0);
        check("ovf_drop_sticky", 32'(drop_flag), 32'h1);

        // Async reset while col1 is still pending.
        nn_spike = 2'b11;
        tick();
        nn_spike = 2'b00;
        tick();
        check("drain_col0_valid", 32'(out_valid), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_addr",  32'(out_addr),  32'h0);
        check("arst_drop_flag", 32'(drop_flag), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_stale", 32'(out_valid), 32'h0);
        end
        nn_spike = 2'b11;
        tick();
        nn_spike = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_table_cleared", 32'(out_valid), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
